// File: rtl/timer_gen.sv
// timer_gen: run/stop timer with compare/wrap pulses, a DIV-cycle tick prescaler,
// a tick counter with a once-per-SEC_DIV-ticks pulse, and an optional edge-triggered
// capture unit. The capture unit is built only when TIMER_GEN_CAPTURE_EN is defined.
// Without it, cap_val, cap_valid and cap_ovr are tied to zero.
module timer_gen #(
   parameter int CNT_W   = 32,
   parameter int DIV     = 1105920,
   parameter int TICK_W  = 16,
   parameter int SEC_DIV = 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              ena,
   input  logic              start,
   input  logic              stop,
   input  logic              mode,
   input  logic [CNT_W-1:0]  cmp_val,
   output logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              pulse_cmp,
   output logic              pulse_full,
   output logic              tick,
   output logic [TICK_W-1:0] tick_cnt,
   output logic              pulse_sec,
   input  logic              cap_trig,
   input  logic              cap_ack,
   output logic [CNT_W-1:0]  cap_val,
   output logic              cap_valid,
   output logic              cap_ovr
);

   localparam int PSC_W = $clog2(DIV);
   localparam int SEC_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    cmp_q, cmp_d;
   logic                mode_q, mode_d;
   logic [PSC_W-1:0]    psc_q, psc_d;
   logic [SEC_W-1:0]    sec_q, sec_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic                pulse_cmp_q, pulse_cmp_d;
   logic                pulse_full_q, pulse_full_d;
   logic                tick_q, tick_d;
   logic                pulse_sec_q, pulse_sec_d;

   logic                run_en;
   logic                at_cmp;
   logic                psc_wrap;
   logic                sec_wrap;

   // stop shadows start and also freezes the counters for that cycle
   assign run_en   = (state_q == RUN) && ena && !stop && !start;
   assign at_cmp   = (count_q == cmp_q);
   assign psc_wrap = (psc_q == PSC_W'(DIV - 1));
   assign sec_wrap = (sec_q == SEC_W'(SEC_DIV - 1));

   // Next-state logic: stop beats start, a one-shot finishing its count parks in DONE
   always_comb begin
      state_d = state_q;
      if (stop) begin
         if (state_q == RUN) state_d = IDLE;
      end else if (start) begin
         state_d = RUN;
      end else if (run_en && at_cmp && mode_q) begin
         state_d = DONE;
      end
   end

   // Counter, prescaler and tick datapath; pulses default low and last one cycle
   always_comb begin
      cmp_d        = cmp_q;
      mode_d       = mode_q;
      count_d      = count_q;
      psc_d        = psc_q;
      sec_d        = sec_q;
      tick_cnt_d   = tick_cnt_q;
      pulse_cmp_d  = 1'b0;
      pulse_full_d = 1'b0;
      tick_d       = 1'b0;
      pulse_sec_d  = 1'b0;
      if (start && !stop) begin
         cmp_d   = cmp_val;
         mode_d  = mode;
         count_d = '0;
         psc_d   = '0;
         sec_d   = '0;
      end else if (run_en) begin
         if (at_cmp) begin
            pulse_cmp_d = 1'b1;
            if (!mode_q) begin
               // count never exceeds cmp_q, so the all-ones wrap only happens here
               count_d      = '0;
               pulse_full_d = &count_q;
            end
         end else begin
            count_d = count_q + CNT_W'(1);
         end
         if (psc_wrap) begin
            psc_d      = '0;
            tick_d     = 1'b1;
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
            if (sec_wrap) begin
               sec_d       = '0;
               pulse_sec_d = 1'b1;
            end else begin
               sec_d = sec_q + SEC_W'(1);
            end
         end else begin
            psc_d = psc_q + PSC_W'(1);
         end
      end
   end

   // State and datapath registers; clr behaves exactly like reset
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         state_q      <= IDLE;
         count_q      <= '0;
         cmp_q        <= '0;
         mode_q       <= 1'b0;
         psc_q        <= '0;
         sec_q        <= '0;
         tick_cnt_q   <= '0;
         pulse_cmp_q  <= 1'b0;
         pulse_full_q <= 1'b0;
         tick_q       <= 1'b0;
         pulse_sec_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         cmp_q        <= cmp_d;
         mode_q       <= mode_d;
         psc_q        <= psc_d;
         sec_q        <= sec_d;
         tick_cnt_q   <= tick_cnt_d;
         pulse_cmp_q  <= pulse_cmp_d;
         pulse_full_q <= pulse_full_d;
         tick_q       <= tick_d;
         pulse_sec_q  <= pulse_sec_d;
      end
   end

   assign count      = count_q;
   assign busy       = (state_q == RUN);
   assign pulse_cmp  = pulse_cmp_q;
   assign pulse_full = pulse_full_q;
   assign tick       = tick_q;
   assign tick_cnt   = tick_cnt_q;
   assign pulse_sec  = pulse_sec_q;

`ifdef TIMER_GEN_CAPTURE_EN
   logic                trig_prev_q, trig_prev_d;
   logic [CNT_W-1:0]    cap_val_q, cap_val_d;
   logic                cap_valid_q, cap_valid_d;
   logic                cap_ovr_q, cap_ovr_d;

   // Capture on a rising cap_trig; a capture coinciding with cap_ack wins and is not an overrun
   always_comb begin
      trig_prev_d = cap_trig;
      cap_val_d   = cap_val_q;
      cap_valid_d = cap_valid_q;
      cap_ovr_d   = cap_ovr_q;
      if (cap_trig && !trig_prev_q) begin
         cap_val_d   = count_q;
         cap_valid_d = 1'b1;
         cap_ovr_d   = cap_valid_q && !cap_ack;
      end else if (cap_ack) begin
         cap_valid_d = 1'b0;
         cap_ovr_d   = 1'b0;
      end
   end

   // Capture registers share the timer's reset and clear
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         trig_prev_q <= 1'b0;
         cap_val_q   <= '0;
         cap_valid_q <= 1'b0;
         cap_ovr_q   <= 1'b0;
      end else begin
         trig_prev_q <= trig_prev_d;
         cap_val_q   <= cap_val_d;
         cap_valid_q <= cap_valid_d;
         cap_ovr_q   <= cap_ovr_d;
      end
   end

   assign cap_val   = cap_val_q;
   assign cap_valid = cap_valid_q;
   assign cap_ovr   = cap_ovr_q;
`else
   logic unused_cap;
   assign unused_cap = cap_trig ^ cap_ack;
   assign cap_val    = '0;
   assign cap_valid  = 1'b0;
   assign cap_ovr    = 1'b0;
`endif

endmodule

// File: tb/tb_timer_gen.sv
// Testbench for timer_gen (CNT_W=4, DIV=4, TICK_W=8, SEC_DIV=3): a behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_timer_gen;

   localparam int CW   = 4;
   localparam int DV   = 4;
   localparam int TW   = 8;
   localparam int SD   = 3;
   localparam int CMAX = 15;
`ifdef TIMER_GEN_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic          clk;
   logic          rst, clr, ena, start, stop, mode;
   logic [CW-1:0] cmp_val;
   logic [CW-1:0] count;
   logic          busy, pulse_cmp, pulse_full, tick, pulse_sec;
   logic [TW-1:0] tick_cnt;
   logic          cap_trig, cap_ack;
   logic [CW-1:0] cap_val;
   logic          cap_valid, cap_ovr;

   int errors = 0;
   int checks = 0;

   timer_gen #(.CNT_W(CW), .DIV(DV), .TICK_W(TW), .SEC_DIV(SD)) dut (
      .clk(clk), .rst(rst), .clr(clr), .ena(ena), .start(start), .stop(stop),
      .mode(mode), .cmp_val(cmp_val), .count(count), .busy(busy),
      .pulse_cmp(pulse_cmp), .pulse_full(pulse_full), .tick(tick),
      .tick_cnt(tick_cnt), .pulse_sec(pulse_sec), .cap_trig(cap_trig),
      .cap_ack(cap_ack), .cap_val(cap_val), .cap_valid(cap_valid), .cap_ovr(cap_ovr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   // Model: phase 0=idle 1=run 2=done; el = enabled run cycles since the last start
   int m_ph = 0, m_el = 0, m_cmp = 0, m_count = 0, m_tcnt = 0, m_cval = 0;
   bit m_one = 0, m_prev = 0, m_cvld = 0, m_covr = 0;
   bit e_pc = 0, e_pf = 0, e_tk = 0, e_ps = 0;

   initial begin
      forever begin
         @(posedge clk);
         e_pc = 0; e_pf = 0; e_tk = 0; e_ps = 0;
         if (!rst || clr) begin
            m_ph = 0; m_el = 0; m_cmp = 0; m_one = 0; m_count = 0; m_tcnt = 0;
            m_prev = 0; m_cval = 0; m_cvld = 0; m_covr = 0;
         end else begin
            if (CAP) begin
               if (cap_trig && !m_prev) begin
                  m_covr = m_cvld && !cap_ack;
                  m_cvld = 1;
                  m_cval = m_count;
               end else if (cap_ack) begin
                  m_cvld = 0;
                  m_covr = 0;
               end
            end
            m_prev = cap_trig;
            if (stop) begin
               if (m_ph == 1) m_ph = 0;
            end else if (start) begin
               m_ph = 1; m_cmp = int'(cmp_val); m_one = mode; m_el = 0; m_count = 0;
            end else if (m_ph == 1 && ena) begin
               m_el++;
               if (m_one) begin
                  m_count = (m_el < m_cmp) ? m_el : m_cmp;
                  if (m_el == m_cmp + 1) begin
                     e_pc = 1;
                     m_ph = 2;
                  end
               end else begin
                  m_count = m_el % (m_cmp + 1);
                  if (m_count == 0) begin
                     e_pc = 1;
                     e_pf = (m_cmp == CMAX);
                  end
               end
               if (m_el % DV == 0) begin
                  e_tk = 1;
                  m_tcnt = (m_tcnt + 1) % (1 << TW);
                  e_ps = ((m_el / DV) % SD == 0);
               end
            end
         end
         @(negedge clk);
         chk("m_count", 32'(count), m_count);
         chk("m_busy", 32'(busy), 32'(m_ph == 1));
         chk("m_pulse_cmp", 32'(pulse_cmp), 32'(e_pc));
         chk("m_pulse_full", 32'(pulse_full), 32'(e_pf));
         chk("m_tick", 32'(tick), 32'(e_tk));
         chk("m_tick_cnt", 32'(tick_cnt), m_tcnt);
         chk("m_pulse_sec", 32'(pulse_sec), 32'(e_ps));
         chk("m_cap_val", 32'(cap_val), m_cval);
         chk("m_cap_valid", 32'(cap_valid), 32'(m_cvld));
         chk("m_cap_ovr", 32'(cap_ovr), 32'(m_covr));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 0; clr = 0; ena = 0; start = 0; stop = 0; mode = 0;
      cmp_val = '0; cap_trig = 0; cap_ack = 0;
      step(2);
      chk("rst_count", 32'(count), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tick_cnt", 32'(tick_cnt), 0);
      rst = 1;

      // periodic, cmp 5, with prescaler and second pulse
      cmp_val = 4'd5; mode = 0; ena = 1; start = 1;
      step(1);
      start = 0;
      for (int i = 0; i <= 26; i++) begin
         chk("per_count", 32'(count), i % 6);
         chk("per_pcmp", 32'(pulse_cmp), 32'(i > 0 && i % 6 == 0));
         chk("per_tick", 32'(tick), 32'(i > 0 && i % 4 == 0));
         chk("per_busy", 32'(busy), 1);
         if (i == 8) chk("per_sec8", 32'(pulse_sec), 0);
         if (i == 12) begin
            chk("per_tcnt12", 32'(tick_cnt), 3);
            chk("per_sec12", 32'(pulse_sec), 1);
         end
         step(1);
      end
      // count is 3 here; stop holds it
      stop = 1;
      step(1);
      stop = 0;
      chk("stop_busy", 32'(busy), 0);
      step(3);
      chk("stop_count", 32'(count), 3);

      // one-shot, cmp 3
      cmp_val = 4'd3; mode = 1; start = 1;
      step(1);
      start = 0;
      for (int i = 0; i <= 7; i++) begin
         chk("os_count", 32'(count), (i < 3) ? i : 3);
         chk("os_pcmp", 32'(pulse_cmp), 32'(i == 4));
         chk("os_busy", 32'(busy), 32'(i <= 3));
         step(1);
      end
      start = 1;
      step(1);
      start = 0;
      chk("os2_busy", 32'(busy), 1);
      chk("os2_count", 32'(count), 0);
      step(4);
      chk("os2_pcmp", 32'(pulse_cmp), 1);
      chk("os2_count3", 32'(count), 3);

      // all-ones terminal count in periodic mode
      cmp_val = 4'd15; mode = 0; start = 1;
      step(1);
      start = 0;
      step(16);
      chk("wrap_count", 32'(count), 0);
      chk("wrap_pcmp", 32'(pulse_cmp), 1);
      chk("wrap_pfull", 32'(pulse_full), 1);
      step(1);
      chk("wrap_pfull_next", 32'(pulse_full), 0);
      chk("wrap_count1", 32'(count), 1);

      // capture at count 7 and 9 without ack
      step(6);
      chk("cap_pre_count", 32'(count), 7);
      cap_trig = 1;
      step(1);
      cap_trig = 0;
      chk("cap1_val", 32'(cap_val), CAP ? 7 : 0);
      chk("cap1_ovr", 32'(cap_ovr), 0);
      step(1);
      cap_trig = 1;
      step(1);
      cap_trig = 0;
      chk("cap2_val", 32'(cap_val), CAP ? 9 : 0);
      chk("cap2_valid", 32'(cap_valid), 32'(CAP));
      chk("cap2_ovr", 32'(cap_ovr), 32'(CAP));
      cap_ack = 1;
      step(1);
      cap_ack = 0;
      chk("ack_valid", 32'(cap_valid), 0);
      chk("ack_ovr", 32'(cap_ovr), 0);
      cap_trig = 1;
      step(1);
      cap_trig = 0;
      step(1);
      cap_trig = 1; cap_ack = 1;
      step(1);
      cap_trig = 0; cap_ack = 0;
      chk("ackcap_valid", 32'(cap_valid), 32'(CAP));
      chk("ackcap_ovr", 32'(cap_ovr), 0);

      // start and stop together while running
      cmp_val = 4'd2; start = 1; stop = 1;
      step(1);
      start = 0; stop = 0;
      chk("ss_busy", 32'(busy), 0);
      step(2);

      // enable low holds everything
      cmp_val = 4'd5; start = 1;
      step(1);
      start = 0; ena = 0;
      step(3);
      chk("ena0_count", 32'(count), 0);
      ena = 1;
      step(2);
      chk("ena1_count", 32'(count), 2);
      chk("ena1_busy", 32'(busy), 1);

      // clr mid-run, at the cycle a compare pulse would be produced
      cmp_val = 4'd2; start = 1;
      step(1);
      start = 0;
      step(2);
      chk("clr_pre_count", 32'(count), 2);
      clr = 1;
      step(1);
      clr = 0;
      chk("clr_count", 32'(count), 0);
      chk("clr_busy", 32'(busy), 0);
      chk("clr_pcmp", 32'(pulse_cmp), 0);
      chk("clr_tick_cnt", 32'(tick_cnt), 0);
      chk("clr_cap_valid", 32'(cap_valid), 0);

      // reset mid-run, same situation
      start = 1;
      step(1);
      start = 0;
      step(2);
      rst = 0;
      step(1);
      rst = 1;
      chk("rstrun_count", 32'(count), 0);
      chk("rstrun_busy", 32'(busy), 0);
      chk("rstrun_pcmp", 32'(pulse_cmp), 0);
      step(3);
      chk("rstrun_idle", 32'(count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/timer_gen.md
TIMER_GEN -- requirements
Module: timer_gen

Interface
REQ-001 Parameter CNT_W, default 32: width of the main counter, compare value and capture value.
REQ-002 Parameter DIV, default 1105920: clk cycles per tick (10 ms at 110.592 MHz), DIV >= 2.
REQ-003 Parameter TICK_W, default 16: width of tick_cnt.
REQ-004 Parameter SEC_DIV, default 100: ticks per pulse_sec, SEC_DIV >= 1.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 clr  in  1  synchronous clear of all state.
REQ-008 ena  in  1  count enable; when low, all counters hold.
REQ-009 start  in  1  one-cycle start/restart strobe.
REQ-010 stop  in  1  one-cycle stop strobe.
REQ-011 mode  in  1  0 = periodic, 1 = one-shot; sampled on accepted start.
REQ-012 cmp_val  in  CNT_W  terminal count; sampled into cmp_reg on accepted start.
REQ-013 count  out  CNT_W  main counter value.
REQ-014 busy  out  1  high while in RUN.
REQ-015 pulse_cmp  out  1  one-cycle pulse on terminal count.
REQ-016 pulse_full  out  1  one-cycle pulse when count passes all-ones.
REQ-017 tick  out  1  one-cycle pulse every DIV enabled RUN cycles.
REQ-018 tick_cnt  out  TICK_W  tick counter, wraps modulo 2^TICK_W.
REQ-019 pulse_sec  out  1  one-cycle pulse every SEC_DIV ticks.
REQ-020 cap_trig  in  1  capture trigger, rising-edge sensitive.
REQ-021 cap_ack  in  1  capture acknowledge.
REQ-022 cap_val  out  CNT_W  captured count.
REQ-023 cap_valid  out  1  capture pending, sticky until cap_ack.
REQ-024 cap_ovr  out  1  overrun, sticky until cap_ack.

Function
REQ-025 The FSM SHALL have states IDLE, RUN and DONE; count and the prescaler SHALL hold in IDLE and DONE.
REQ-026 start in any state SHALL enter RUN, load cmp_reg and mode, and zero count, the prescaler and the second counter; tick_cnt is untouched.
REQ-027 stop SHALL move RUN to IDLE with count held; start and stop asserted together: stop wins.
REQ-028 In RUN with ena high, count SHALL increment by 1 per cycle; at count == cmp_reg, pulse_cmp SHALL be high the following cycle.
REQ-029 Periodic: at count == cmp_reg with ena, count SHALL reload 0 and stay in RUN; cmp_reg == 0 gives pulse_cmp every enabled cycle.
REQ-030 One-shot: at count == cmp_reg with ena, count SHALL hold at cmp_reg and the FSM SHALL enter DONE (busy low the following cycle).
REQ-031 count == all-ones with ena in RUN (cmp_reg all-ones) SHALL wrap to 0 and pulse_full the following cycle.
REQ-032 The prescaler SHALL count 0..DIV-1 in RUN with ena; at DIV-1 it wraps and tick is high the following cycle.
REQ-033 Each tick SHALL increment tick_cnt; every SEC_DIV-th tick SHALL produce pulse_sec coincident with that tick.
REQ-034 A cap_trig 0->1 transition (registered previous value) SHALL load cap_val <= count and set cap_valid, in any state.
REQ-035 A capture while cap_valid is set SHALL overwrite cap_val and set cap_ovr.
REQ-036 cap_ack SHALL clear cap_valid and cap_ovr; a capture in the same cycle wins, setting cap_valid and leaving cap_ovr clear.
REQ-037 clr SHALL have priority over every other input except rst and produce the reset state.

Reset
REQ-038 On rst low at a clk edge: state IDLE; count, cmp_reg, prescaler, second counter, tick_cnt, cap_val = 0; all pulses, busy, cap_valid, cap_ovr = 0.
REQ-039 Reset mid-RUN SHALL abort the run with no pulse emitted in the following cycle.

Configuration
REQ-040 Macro TIMER_GEN_CAPTURE_EN defined: capture logic per REQ-034..036 present.
REQ-041 Macro undefined: cap_val, cap_valid and cap_ovr SHALL be constant 0; cap_trig and cap_ack are ignored.

Verification
REQ-042 DIV=4, SEC_DIV=3: start, ena=1 -> tick every 4 cycles, pulse_sec every 12, tick_cnt 1, 2, 3.
REQ-043 Periodic, cmp_val=5 -> count 0..5,0..; pulse_cmp every 6 cycles, busy stays 1.
REQ-044 One-shot, cmp_val=3 -> count holds 3, one pulse_cmp, DONE, busy 0; a second start reruns.
REQ-045 CNT_W=4, cmp_val=15, periodic -> count wraps 15->0 with pulse_cmp and pulse_full in the same cycle.
REQ-046 Two cap_trig edges at count 7 and 9 without ack -> cap_val 9, cap_valid 1, cap_ovr 1; cap_ack clears both; macro off -> all 0.
REQ-047 start+stop together -> IDLE; clr or rst mid-RUN -> all outputs 0 the next cycle.
